fetch_sched: RTL and testbench

Instruction-fetch scheduler in the IF stage. Drives the PC register's `enable` / `is_branch` / `branch_address` inputs and the instruction-bus request, delivers fetched words to ID, and applies branch and flush (exception/ERET) redirects. A single-entry skid buffer absorbs one fetched word while ID stalls. Branch delay-slot semantics are exact.

---
 rtl/fetch_sched.sv | 259 +++++++++++++++++++++++++
 tb/tb_fetch_sched.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sched.sv
// fetch_sched -- instruction-fetch scheduler for the IF stage.
//
// Runs one instruction-bus request at a time at the address held in the
// external PC register. It tells that register when to advance (PC+4) and
// when to load a redirect target. Fetched words are registered toward ID.
// A single-entry skid buffer catches the one word that can arrive while ID
// is stalled. Branches follow exact delay-slot semantics. Exception/ERET
// flushes take priority over branches.
//
// Optional build feature:
//   FETCH_SCHED_PERF_EN  when defined, stall_cycles counts the REQ/DRAIN
//                        cycles that have no ibus_ack (32-bit, wraps).
//                        When undefined, stall_cycles is tied to zero.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   pc_reg              current PC from the PC register
//   pc_enable           PC advance strobe
//   pc_is_branch        load pc_branch_address instead of PC+4
//   pc_branch_address   redirect target
//   ibus_req/ibus_addr  fetch request; the address is always pc_reg
//   ibus_ack/ibus_rdata fetch done; the data is valid in the ack cycle
//   if_valid/if_inst/if_pc  registered instruction to ID
//   id_stall            ID cannot accept; if_* hold
//   br_valid/br_target  taken branch held in ID (level)
//   flush_valid/flush_target  one-cycle exception/ERET redirect
//   stall_cycles        fetch wait-cycle counter (see FETCH_SCHED_PERF_EN)

module fetch_sched #(
    parameter logic [31:0] RESET_PC = 32'h1fc00000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_reg,
    output logic        pc_enable,
    output logic        pc_is_branch,
    output logic [31:0] pc_branch_address,
    output logic        ibus_req,
    output logic [31:0] ibus_addr,
    input  logic        ibus_ack,
    input  logic [31:0] ibus_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    input  logic        id_stall,
    input  logic        br_valid,
    input  logic [31:0] br_target,
    input  logic        flush_valid,
    input  logic [31:0] flush_target,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q;
    state_t      state_d;

    // Control registers (reset)
    logic        br_pend_q;

    // Data registers (no reset; only read when their qualifying state is set)
    logic [31:0] skid_inst;
    logic [31:0] skid_pc;
    logic [31:0] br_pend_target;
    logic [31:0] drain_target;

    // Per-cycle update controls produced by the next-state logic
    logic        load_if;     // bus word goes straight to ID
    logic        take_skid;   // skid word goes to ID
    logic        clr_if;      // ID slot empties (consumed or flushed)
    logic        load_skid;   // bus word is parked in the skid buffer
    logic        set_pend;    // branch left ID before its delay slot arrived
    logic        clr_pend;
    logic        load_drain;  // remember the flush target while the bus drains

    // The bus is only ever asked for the current PC.
    assign ibus_addr = pc_reg;

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d           = state_q;
        ibus_req          = 1'b0;
        pc_enable         = 1'b0;
        pc_is_branch      = 1'b0;
        pc_branch_address = '0;
        load_if           = 1'b0;
        take_skid         = 1'b0;
        clr_if            = 1'b0;
        load_skid         = 1'b0;
        set_pend          = 1'b0;
        clr_pend          = 1'b0;
        load_drain        = 1'b0;

        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (flush_valid) begin
                    pc_enable         = 1'b1;
                    pc_is_branch      = 1'b1;
                    pc_branch_address = flush_target;
                    clr_if            = 1'b1;
                    clr_pend          = 1'b1;
                end
            end

            REQ: begin
                ibus_req = 1'b1;
                if (flush_valid) begin
                    clr_if   = 1'b1;
                    clr_pend = 1'b1;
                    if (ibus_ack) begin
                        // Word is dropped; the PC jumps straight to the target.
                        pc_enable         = 1'b1;
                        pc_is_branch      = 1'b1;
                        pc_branch_address = flush_target;
                    end else begin
                        // The request cannot be withdrawn, so wait for it in DRAIN.
                        load_drain = 1'b1;
                        state_d    = DRAIN;
                    end
                end else if (ibus_ack) begin
                    pc_enable = 1'b1;
                    clr_pend  = 1'b1;
                    // Any branch still outstanding makes this word its delay slot.
                    if (br_pend_q) begin
                        pc_is_branch      = 1'b1;
                        pc_branch_address = br_pend_target;
                    end else if (br_valid) begin
                        pc_is_branch      = 1'b1;
                        pc_branch_address = br_target;
                    end
                    if (!if_valid || !id_stall) begin
                        load_if = 1'b1;
                    end else begin
                        load_skid = 1'b1;
                        state_d   = HOLD;
                    end
                end else begin
                    if (!id_stall) begin
                        clr_if = 1'b1;
                    end
                    if (br_valid && !id_stall) begin
                        set_pend = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (flush_valid) begin
                    pc_enable         = 1'b1;
                    pc_is_branch      = 1'b1;
                    pc_branch_address = flush_target;
                    clr_if            = 1'b1;
                    clr_pend          = 1'b1;
                    state_d           = REQ;
                end else if (!id_stall) begin
                    take_skid = 1'b1;
                    state_d   = REQ;
                end
            end

            DRAIN: begin
                ibus_req = 1'b1;
                if (flush_valid) begin
                    clr_pend = 1'b1;
                end
                if (ibus_ack) begin
                    // A flush arriving in the ack cycle is the newest target.
                    pc_enable         = 1'b1;
                    pc_is_branch      = 1'b1;
                    pc_branch_address = flush_valid ? flush_target : drain_target;
                    state_d           = REQ;
                end else if (flush_valid) begin
                    load_drain = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and ID-facing registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            if_valid  <= 1'b0;
            if_inst   <= '0;
            if_pc     <= RESET_PC;
            br_pend_q <= 1'b0;
        end else begin
            state_q <= state_d;

            if (clr_if) begin
                if_valid <= 1'b0;
            end else if (load_if) begin
                if_valid <= 1'b1;
                if_inst  <= ibus_rdata;
                if_pc    <= pc_reg;
            end else if (take_skid) begin
                if_valid <= 1'b1;
                if_inst  <= skid_inst;
                if_pc    <= skid_pc;
            end

            if (clr_pend) begin
                br_pend_q <= 1'b0;
            end else if (set_pend) begin
                br_pend_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_inst <= ibus_rdata;
            skid_pc   <= pc_reg;
        end
        if (set_pend) begin
            br_pend_target <= br_target;
        end
        if (load_drain) begin
            drain_target <= flush_target;
        end
    end

    // ------------------------------------------------------------------
    // Fetch wait-cycle counter
    // ------------------------------------------------------------------
`ifdef FETCH_SCHED_PERF_EN
    logic        count_stall;
    logic [31:0] stall_cnt_q;

    assign count_stall = ((state_q == REQ) || (state_q == DRAIN)) && !ibus_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (count_stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_fetch_sched.sv
`timescale 1ns/1ps
module tb_fetch_sched;

    localparam logic [31:0] RESET_PC = 32'h1fc00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_q;
    logic        pc_enable;
    logic        pc_is_branch;
    logic [31:0] pc_branch_address;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack = 1'b0;
    logic [31:0] ibus_rdata = '0;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        id_stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [31:0] br_target = '0;
    logic        flush_valid = 1'b0;
    logic [31:0] flush_target = '0;
    logic [31:0] stall_cycles;

    always #5 clk = ~clk;

    fetch_sched #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .pc_reg            (pc_q),
        .pc_enable         (pc_enable),
        .pc_is_branch      (pc_is_branch),
        .pc_branch_address (pc_branch_address),
        .ibus_req          (ibus_req),
        .ibus_addr         (ibus_addr),
        .ibus_ack          (ibus_ack),
        .ibus_rdata        (ibus_rdata),
        .if_valid          (if_valid),
        .if_inst           (if_inst),
        .if_pc             (if_pc),
        .id_stall          (id_stall),
        .br_valid          (br_valid),
        .br_target         (br_target),
        .flush_valid       (flush_valid),
        .flush_target      (flush_target),
        .stall_cycles      (stall_cycles)
    );

    // The PC register that the scheduler steers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc_q <= RESET_PC;
        else if (pc_enable)
            pc_q <= pc_is_branch ? pc_branch_address : pc_q + 32'd4;
    end

    int total = 0;
    int bad   = 0;

    // Stimulus knobs
    int          lat_min, lat_max, stall_pct, flush_pct, stall_force;
    bit          rnd_br, dir_br, fl_armed;
    logic [31:0] dir_br_pc, dir_br_tgt, fl_addr, fl_tgt;
    int          wait_left;

    // Architectural reference: the program-order stream ID must see
    logic [31:0] exp_pc, ds_tgt;
    bit          ds_pend;
`ifdef FETCH_SCHED_PERF_EN
    logic [31:0] exp_stall;
`endif

    // Logs
    logic [31:0] ack_log[$];
    logic [31:0] cons_log[$];
    logic        req_log[64];
    logic [31:0] addr_log[64];
    logic        vld_log[64];
    logic [31:0] ifpc_log[64];
    int          nstep, ack_cnt;
    bit          s_req, s_pcen, s_vld;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5a5a_0013 ^ {a[15:0], 16'h0};
    endfunction

    function automatic bit is_branch_pc(input logic [31:0] a);
        return (dir_br && a == dir_br_pc) || (rnd_br && a[4:2] == 3'd5);
    endfunction

    function automatic logic [31:0] br_tgt_of(input logic [31:0] a);
        if (dir_br && a == dir_br_pc)
            return dir_br_tgt;
        return {16'h8001, a[15:2] ^ 14'h2c3, 2'b00};
    endfunction

    function automatic int pick_lat();
        return int'($urandom_range(lat_max, lat_min));
    endfunction

    function automatic logic [31:0] ack_at(input int i);
        return (ack_log.size() > i) ? ack_log[i] : 32'hdead_beef;
    endfunction

    function automatic logic [31:0] cons_at(input int i);
        return (cons_log.size() > i) ? cons_log[i] : 32'hdead_beef;
    endfunction

    // One clock cycle: drive at the falling edge, check 1ns later.
    task automatic step();
        logic [13:0] r14;
        @(negedge clk);
        if (stall_force > 0) begin
            id_stall = 1'b1;
            stall_force--;
        end else begin
            id_stall = ($urandom_range(99, 0) < stall_pct);
        end
        br_valid  = if_valid && !ds_pend && is_branch_pc(if_pc);
        br_target = br_tgt_of(if_pc);

        flush_valid  = 1'b0;
        r14          = 14'($urandom);
        flush_target = {16'h8000, r14, 2'b00};
        if (fl_armed && ibus_req && pc_q == fl_addr && wait_left == 2) begin
            flush_valid  = 1'b1;
            flush_target = fl_tgt;
            fl_armed     = 1'b0;
        end else if ($urandom_range(99, 0) < flush_pct) begin
            flush_valid = 1'b1;
        end

        ibus_ack   = 1'b0;
        ibus_rdata = $urandom;
        if (ibus_req) begin
            if (wait_left == 0) begin
                ibus_ack   = 1'b1;
                ibus_rdata = mem_word(ibus_addr);
                wait_left  = pick_lat();
            end else begin
                wait_left--;
            end
        end
        #1;

        s_req  = ibus_req;
        s_pcen = pc_enable;
        s_vld  = if_valid;
        if (nstep < 64) begin
            req_log[nstep]  = ibus_req;
            addr_log[nstep] = ibus_addr;
            vld_log[nstep]  = if_valid;
            ifpc_log[nstep] = if_pc;
        end
        nstep++;

        if (ibus_req)
            chk("ibus_addr", ibus_addr, pc_q);
        chk("pc_en_cause", 32'(pc_enable && !(ibus_req && ibus_ack) && !flush_valid), 0);
        if (ibus_req && ibus_ack) begin
            chk("pc_en_on_ack", 32'(pc_enable), 1);
            ack_log.push_back(ibus_addr);
            ack_cnt++;
        end

`ifdef FETCH_SCHED_PERF_EN
        chk("stall_cycles", stall_cycles, exp_stall);
        if (ibus_req && !ibus_ack)
            exp_stall++;
`else
        chk("stall_cycles", stall_cycles, 0);
`endif

        if (flush_valid) begin
            ds_pend = 1'b0;
            exp_pc  = flush_target;
        end else if (if_valid && !id_stall) begin
            chk("if_pc", if_pc, exp_pc);
            chk("if_inst", if_inst, mem_word(if_pc));
            cons_log.push_back(if_pc);
            if (ds_pend) begin
                exp_pc  = ds_tgt;
                ds_pend = 1'b0;
            end else if (br_valid) begin
                ds_pend = 1'b1;
                ds_tgt  = br_target;
                exp_pc  = if_pc + 32'd4;
            end else begin
                exp_pc = if_pc + 32'd4;
            end
        end
    endtask

    // Asynchronous reset, asserted between clock edges.
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_ibus_req", 32'(ibus_req), 0);
        chk("rst_if_valid", 32'(if_valid), 0);
        id_stall    = 1'b0;
        br_valid    = 1'b0;
        flush_valid = 1'b0;
        ibus_ack    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_if_pc", if_pc, RESET_PC);
        chk("rst_if_inst", if_inst, 0);
        chk("rst_pc_enable", 32'(pc_enable), 0);
        chk("rst_stall_cycles", stall_cycles, 0);
        wait_left   = pick_lat();
        exp_pc      = RESET_PC;
        ds_pend     = 1'b0;
`ifdef FETCH_SCHED_PERF_EN
        exp_stall   = '0;
`endif
        ack_log.delete();
        cons_log.delete();
        nstep       = 0;
        ack_cnt     = 0;
        stall_force = 0;
        fl_armed    = 1'b0;
        rst_n       = 1'b1;
    endtask

    task automatic knobs(input int lmin, input int lmax, input int spct, input int fpct,
                         input bit rbr, input bit dbr);
        lat_min   = lmin;
        lat_max   = lmax;
        stall_pct = spct;
        flush_pct = fpct;
        rnd_br    = rbr;
        dir_br    = dbr;
    endtask

    initial begin
        bit seen;
        int en_cnt, low_cnt;
        dir_br_pc  = RESET_PC + 32'd4;
        dir_br_tgt = 32'h8000_1000;

        // Zero-wait bus: back-to-back fetch, one-cycle delivery latency.
        knobs(0, 0, 0, 0, 0, 0);
        do_reset();
        repeat (8) step();
        chk("t1_req_first", 32'(req_log[0]), 1);
        chk("t1_vld_first", 32'(vld_log[0]), 0);
        for (int i = 0; i < 3; i++) begin
            chk("t1_addr", addr_log[i], RESET_PC + 32'(4 * i));
            chk("t1_if_pc", ifpc_log[i + 1], RESET_PC + 32'(4 * i));
            chk("t1_if_valid", 32'(vld_log[i + 1]), 1);
        end

        // Branch in ID when its delay slot is acked.
        knobs(0, 0, 0, 0, 0, 1);
        do_reset();
        repeat (8) step();
        chk("t2_ack2", ack_at(2), 32'h1fc0_0008);
        chk("t2_ack3", ack_at(3), 32'h8000_1000);
        chk("t2_cons2", cons_at(2), 32'h1fc0_0008);
        chk("t2_cons3", cons_at(3), 32'h8000_1000);

        // Branch leaves ID before its delay slot returns (3-cycle bus).
        knobs(2, 2, 0, 0, 0, 1);
        do_reset();
        repeat (20) step();
        chk("t3_ack2", ack_at(2), 32'h1fc0_0008);
        chk("t3_ack3", ack_at(3), 32'h8000_1000);
        chk("t3_cons2", cons_at(2), 32'h1fc0_0008);
        chk("t3_cons3", cons_at(3), 32'h8000_1000);

        // ID stall for 4 cycles: one word parks, request drops, PC moves once.
        knobs(0, 0, 0, 0, 0, 0);
        do_reset();
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            seen = s_vld;
        end
        chk("t4_vld_seen", 32'(seen), 1);
        stall_force = 4;
        en_cnt  = 0;
        low_cnt = 0;
        repeat (4) begin
            step();
            en_cnt  += int'(s_pcen);
            low_cnt += int'(!s_req);
        end
        chk("t4_pc_adv", 32'(en_cnt), 1);
        chk("t4_req_low", 32'(low_cnt), 3);
        repeat (6) step();
        for (int i = 0; i < 5; i++)
            chk("t4_order", cons_at(i), RESET_PC + 32'(4 * i));

        // Flush while a 5-cycle fetch is outstanding and a branch is pending.
        knobs(4, 4, 0, 0, 0, 1);
        do_reset();
        fl_armed = 1'b1;
        fl_addr  = 32'h1fc0_0008;
        fl_tgt   = 32'h8000_0180;
        repeat (30) step();
        chk("t5_ack2", ack_at(2), 32'h1fc0_0008);
        chk("t5_ack3", ack_at(3), 32'h8000_0180);
        chk("t5_cons1", cons_at(1), 32'h1fc0_0004);
        chk("t5_cons2", cons_at(2), 32'h8000_0180);
        chk("t5_cons3", cons_at(3), 32'h8000_0184);

        // Wait-cycle counter: 10 fetches at 2 wait cycles each.
        knobs(2, 2, 0, 0, 0, 0);
        do_reset();
        for (int k = 0; k < 100 && ack_cnt < 10; k++)
            step();
        chk("t6_acks", 32'(ack_cnt), 10);
        @(posedge clk);
        #1;
`ifdef FETCH_SCHED_PERF_EN
        chk("t6_stall_cycles", stall_cycles, 32'd20);
`else
        chk("t6_stall_cycles", stall_cycles, 32'd0);
`endif

        // Randomized traffic, with a reset landing mid-stream.
        knobs(0, 3, 30, 4, 1, 0);
        do_reset();
        repeat (3000) step();
        chk("rnd_progress", 32'(cons_log.size() > 300), 1);
        do_reset();
        repeat (1500) step();
        chk("rnd_progress2", 32'(cons_log.size() > 150), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
